fmap_streamer: RTL



---
 rtl/fmap_pkg.sv | 16 +
 rtl/fmap_ram.sv | 24 ++
 rtl/fmap_streamer.sv | 117 +++++++++++
 3 files changed

// File: rtl/fmap_pkg.sv
// Shared defaults and state encoding for the feature-map streamer and the
// convolver-side benches.
package fmap_pkg;

  localparam int unsigned DEF_N   = 16;
  localparam int unsigned DEF_DIM = 6;
  localparam int unsigned FRAME   = DEF_DIM * DEF_DIM;
  localparam int unsigned DEF_AW  = $clog2(FRAME);
  localparam int unsigned Q_FRAC  = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } fmap_state_e;

endpackage

// File: rtl/fmap_ram.sv
// Frame store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module fmap_ram #(
  parameter int unsigned N     = 16,
  parameter int unsigned DEPTH = 36,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fmap_streamer.sv
// Holds one n x n activation frame and streams it in raster order over a
// valid/ready handshake, optionally replaying it back-to-back.
module fmap_streamer
  import fmap_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned n  = DEF_DIM,
  parameter int unsigned AW = $clog2(n * n)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  output logic          wr_err,
  input  logic          start,
  input  logic          loop,
  input  logic          act_ready,
  output logic [N-1:0]  act_out,
  output logic          act_valid,
  output logic          act_eol,
  output logic          act_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned WORDS    = n * n;
  localparam int unsigned CW       = (n > 1) ? $clog2(n) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(WORDS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(n - 1);

  fmap_state_e   state_q, state_d;
  logic [AW-1:0] rd_ptr, ptr_d;
  logic [CW-1:0] col, col_d;
  logic          done_d, wr_err_d, stream_d;
  logic          wr_commit_c, xfer_c;
  logic [N-1:0]  ram_rd, word_d;

  assign wr_commit_c = wr_en && (state_q == IDLE) &&
                       ({1'b0, wr_addr} < (AW + 1)'(WORDS));
  assign xfer_c      = (state_q == STREAM) && act_ready;

  // The RAM is read at the pointer of the word presented next cycle.
  fmap_ram #(.N(N), .DEPTH(WORDS), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (wr_commit_c),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ptr_d),
    .rd_data (ram_rd)
  );

  // A write landing in the same cycle as start must be seen by the first word.
  assign word_d = (wr_commit_c && (wr_addr == ptr_d)) ? wr_data : ram_rd;

  always_comb begin
    state_d  = state_q;
    ptr_d    = rd_ptr;
    col_d    = col;
    done_d   = 1'b0;
    wr_err_d = wr_en && !wr_commit_c;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          ptr_d   = '0;
          col_d   = '0;
        end
      end
      STREAM: begin
        if (xfer_c) begin
          if (rd_ptr == LAST_PTR) begin
            ptr_d = '0;
            col_d = '0;
            if (!loop) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            ptr_d = rd_ptr + AW'(1);
            col_d = (col == LAST_COL) ? '0 : col + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    stream_d = (state_d == STREAM);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_ptr    <= '0;
      col       <= '0;
      act_out   <= '0;
      act_valid <= 1'b0;
      act_eol   <= 1'b0;
      act_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr    <= ptr_d;
      col       <= col_d;
      act_out   <= stream_d ? word_d : '0;
      act_valid <= stream_d;
      act_eol   <= stream_d && (col_d == LAST_COL);
      act_last  <= stream_d && (ptr_d == LAST_PTR);
      busy      <= stream_d;
      done      <= done_d;
      wr_err    <= wr_err_d;
    end
  end

endmodule
